// File: rtl/i2s_rx_deserializer.sv
// rtl/i2s_rx_deserializer.sv - I2S record-path deserializer producing stereo pairs on valid/ready
// Oversamples bclk/lrc/data in the mclk domain; one-bit-delayed I2S framing, MSB first.
module i2s_rx_deserializer #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  mclk,
  input  logic                  rst,
  input  logic                  audio_I2S_bclk,
  input  logic                  audio_I2S_reclrc,
  input  logic                  audio_I2S_recdat,
  output logic [DATA_WIDTH-1:0] left_sample,
  output logic [DATA_WIDTH-1:0] right_sample,
  output logic                  sample_valid,
  input  logic                  sample_ready,
  output logic                  overrun,
  output logic                  frame_err
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [1:0] {
    WAIT_SYNC,
    SHIFT,
    PAD
  } state_t;

  state_t                state;
  logic                  bclk_m, bclk_s, bclk_d;
  logic                  lrc_m, lrc_s;
  logic                  dat_m, dat_s;
  logic                  lrc_prev;
  logic                  primed;
  logic                  chan;
  logic                  have_left;
  logic [CNT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-2:0] shreg;
  logic [DATA_WIDTH-1:0] left_hold;

  logic                  rise;
  logic                  transition;
  logic                  shift_en;
  logic                  last_bit;
  logic                  pair_done;
  logic                  load;
  logic [DATA_WIDTH-1:0] word;

  always_ff @(posedge mclk) begin
    if (rst) begin
      bclk_m <= 1'b0;
      bclk_s <= 1'b0;
      bclk_d <= 1'b0;
      lrc_m  <= 1'b0;
      lrc_s  <= 1'b0;
      dat_m  <= 1'b0;
      dat_s  <= 1'b0;
    end else begin
      bclk_m <= audio_I2S_bclk;
      bclk_s <= bclk_m;
      bclk_d <= bclk_s;
      lrc_m  <= audio_I2S_reclrc;
      lrc_s  <= lrc_m;
      dat_m  <= audio_I2S_recdat;
      dat_s  <= dat_m;
    end
  end

  // The first rise after reset only records the LR level, so a reset released
  // mid right-slot does not masquerade as a transition and cause a frame error.
  always_comb begin
    rise       = bclk_s & ~bclk_d;
    transition = rise & primed & (lrc_s != lrc_prev);
    shift_en   = rise & ~transition & (state == SHIFT);
    last_bit   = shift_en & (bit_cnt == CNT_W'(DATA_WIDTH - 1));
    word       = {shreg, dat_s};
    pair_done  = last_bit & chan & have_left;
    load       = pair_done & (~sample_valid | sample_ready);
  end

  always_ff @(posedge mclk) begin
    if (rst) begin
      state        <= WAIT_SYNC;
      lrc_prev     <= 1'b0;
      primed       <= 1'b0;
      chan         <= 1'b0;
      have_left    <= 1'b0;
      bit_cnt      <= '0;
      shreg        <= '0;
      left_hold    <= '0;
      left_sample  <= '0;
      right_sample <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;

      if (rise) begin
        lrc_prev <= lrc_s;
        primed   <= 1'b1;
      end

      case (state)
        WAIT_SYNC: begin
          if (transition) begin
            state   <= SHIFT;
            chan    <= lrc_s;
            bit_cnt <= '0;
          end
        end
        SHIFT: begin
          if (transition) begin
            frame_err <= 1'b1;
            have_left <= 1'b0;
            chan      <= lrc_s;
            bit_cnt   <= '0;
          end else if (shift_en) begin
            shreg   <= word[DATA_WIDTH-2:0];
            bit_cnt <= bit_cnt + CNT_W'(1);
            if (last_bit) begin
              state <= PAD;
              if (!chan) begin
                left_hold <= word;
                have_left <= 1'b1;
              end else begin
                // A right word without a preceding left word is simply dropped.
                have_left <= 1'b0;
              end
            end
          end
        end
        PAD: begin
          if (transition) begin
            state   <= SHIFT;
            chan    <= lrc_s;
            bit_cnt <= '0;
          end
        end
        default: state <= WAIT_SYNC;
      endcase

      if (pair_done) begin
        if (load) begin
          left_sample  <= left_hold;
          right_sample <= word;
          sample_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (sample_valid && sample_ready) begin
        sample_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2s_rx_deserializer.sv
// tb/tb_i2s_rx_deserializer.sv - self-checking bench for i2s_rx_deserializer
// Slot-level reference model; random frames plus directed reset/backpressure/short-slot cases.
module tb_i2s_rx_deserializer;
  localparam int DW = 16;

  logic          mclk = 1'b0;
  logic          rst = 1'b1;
  logic          bclk = 1'b0;
  logic          lrc = 1'b0;
  logic          dat = 1'b0;
  logic          ready = 1'b1;
  logic [DW-1:0] left_sample, right_sample;
  logic          sample_valid, overrun, frame_err;

  i2s_rx_deserializer #(.DATA_WIDTH(DW)) dut (
    .mclk            (mclk),
    .rst             (rst),
    .audio_I2S_bclk  (bclk),
    .audio_I2S_reclrc(lrc),
    .audio_I2S_recdat(dat),
    .left_sample     (left_sample),
    .right_sample    (right_sample),
    .sample_valid    (sample_valid),
    .sample_ready    (ready),
    .overrun         (overrun),
    .frame_err       (frame_err)
  );

  always #5 mclk = ~mclk;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Monitor: accepted pairs, pulse counts, and stability while stalled.
  logic [31:0] got_q[$];
  int          ovr_cnt = 0;
  int          err_cnt = 0;
  bit          hold_v = 0;
  logic [31:0] hold_pair;

  always @(negedge mclk) begin
    if (!rst) begin
      if (overrun) ovr_cnt++;
      if (frame_err) err_cnt++;
      if (sample_valid && ready) got_q.push_back({left_sample, right_sample});
      if (hold_v)
        check_eq("hold_stable", {31'd0, sample_valid, left_sample, right_sample}, {31'd0, 1'b1, hold_pair});
      hold_v    = sample_valid && !ready;
      hold_pair = {left_sample, right_sample};
    end else begin
      hold_v = 0;
    end
  end

  // Reference model, one call per LR slot.
  bit          m_fresh = 1, m_synced = 0, m_incomplete = 0, m_have_left = 0, m_occ = 0, m_ready = 1;
  logic [15:0] m_left;
  logic [31:0] m_held;
  logic [31:0] exp_q[$];
  int          exp_ovr = 0;
  int          exp_err = 0;

  function automatic void model_clear();
    m_have_left  = 0;
    m_occ        = 0;
    m_synced     = 0;
    m_incomplete = 0;
  endfunction

  // mode: 0 normal, 1 whole slot in reset, 2 reset released mid-slot, 3 reset pulse mid-slot
  function automatic void model_slot(input bit ch, input logic [15:0] w, input int len, input int mode);
    if (mode == 1 || mode == 2) begin
      model_clear();
      if (mode == 2) m_fresh = 0;
      return;
    end
    if (m_fresh) begin
      m_fresh = 0;
    end else begin
      if (m_synced && m_incomplete) begin
        exp_err++;
        m_have_left = 0;
      end
      m_synced = 1;
    end
    if (mode == 3) begin
      model_clear();
      m_fresh = 0;
      return;
    end
    if (!m_synced) return;
    if (len - 1 < DW) begin
      m_incomplete = 1;
      return;
    end
    m_incomplete = 0;
    if (!ch) begin
      m_have_left = 1;
      m_left      = w;
    end else if (m_have_left) begin
      m_have_left = 0;
      if (m_occ) exp_ovr++;
      else if (m_ready) exp_q.push_back({m_left, w});
      else begin
        m_occ  = 1;
        m_held = {m_left, w};
      end
    end
  endfunction

  task automatic set_ready(input bit r);
    m_ready = r;
    if (r && m_occ) begin
      exp_q.push_back(m_held);
      m_occ = 0;
    end
    ready = r;
  endtask

  // Entered and left at posedge+1; each bclk period is 4 mclk (2 low, 2 high).
  task automatic send_slot(input bit ch, input logic [15:0] w, input int len,
                           input int mode = 0, input int ra = -1, input int rr = -1);
    model_slot(ch, w, len, mode);
    for (int k = 0; k < len; k++) begin
      bclk = 1'b0;
      if (k == 0) lrc = ch;
      if (k >= 1 && k <= DW && k <= len - 1) dat = w[DW-k];
      else dat = 1'($urandom);
      if (k == ra) rst = 1'b1;
      if (k == rr) rst = 1'b0;
      repeat (2) @(posedge mclk);
      #1;
      if (k == ra) begin
        check_eq("rst_mid_valid", {63'd0, sample_valid}, 64'd0);
        check_eq("rst_mid_data", {32'd0, left_sample, right_sample}, 64'd0);
      end
      bclk = 1'b1;
      repeat (2) @(posedge mclk);
      #1;
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int base_sz;
  int base_err;

  initial begin
    @(posedge mclk);
    #1;
    // Reset with toggling inputs
    for (int i = 0; i < 6; i++) begin
      bclk = 1'($urandom);
      lrc  = 1'($urandom);
      dat  = 1'($urandom);
      @(posedge mclk);
      #1;
    end
    bclk = 1'b0;
    lrc  = 1'b0;
    repeat (2) @(posedge mclk);
    #1;
    check_eq("rst_valid", {63'd0, sample_valid}, 64'd0);
    check_eq("rst_left", {48'd0, left_sample}, 64'd0);
    check_eq("rst_right", {48'd0, right_sample}, 64'd0);
    check_eq("rst_pulses", {62'd0, overrun, frame_err}, 64'd0);
    rst = 1'b0;

    // Basic capture: first frame only synchronises
    send_slot(0, 16'($urandom), 32);
    send_slot(1, 16'($urandom), 32);
    check_eq("no_valid_first_frame", 64'(got_q.size()), 64'd0);
    send_slot(0, 16'hA5C3, 32);
    send_slot(1, 16'h3C5A, 32);
    check_eq("basic_count", 64'(got_q.size()), 64'd1);
    if (got_q.size() > 0) check_eq("basic_pair", 64'(got_q[$]), 64'hA5C33C5A);
    check_eq("basic_no_err", 64'(err_cnt + ovr_cnt), 64'd0);

    // Backpressure across two frames
    set_ready(0);
    send_slot(0, 16'h1111, 32);
    send_slot(1, 16'h2222, 32);
    send_slot(0, 16'h3333, 32);
    send_slot(1, 16'h4444, 32);
    check_eq("bp_valid", {63'd0, sample_valid}, 64'd1);
    check_eq("bp_hold", {32'd0, left_sample, right_sample}, 64'h11112222);
    check_eq("bp_overrun", 64'(ovr_cnt), 64'd1);
    set_ready(1);
    @(posedge mclk);
    #1;
    check_eq("bp_release", {63'd0, sample_valid}, 64'd0);
    if (got_q.size() > 0) check_eq("bp_accepted", 64'(got_q[$]), 64'h11112222);

    // Short left slot (10 bits) then a good frame
    base_sz  = got_q.size();
    base_err = err_cnt;
    send_slot(0, 16'h0F0F, 11);
    send_slot(1, 16'($urandom), 32);
    check_eq("short_err", 64'(err_cnt - base_err), 64'd1);
    check_eq("short_no_valid", 64'(got_q.size() - base_sz), 64'd0);
    send_slot(0, 16'h0F0F, 32);
    send_slot(1, 16'hF0F0, 32);
    check_eq("short_recover_cnt", 64'(got_q.size() - base_sz), 64'd1);
    if (got_q.size() > 0) check_eq("short_recover", 64'(got_q[$]), 64'h0F0FF0F0);

    // Reset released halfway through a right slot
    base_sz  = got_q.size();
    base_err = err_cnt;
    rst = 1'b1;
    send_slot(0, 16'($urandom), 32, 1);
    send_slot(1, 16'($urandom), 32, 2, -1, 16);
    send_slot(0, 16'h1234, 32);
    send_slot(1, 16'h5678, 32);
    check_eq("midstart_cnt", 64'(got_q.size() - base_sz), 64'd1);
    if (got_q.size() > 0) check_eq("midstart_pair", 64'(got_q[$]), 64'h12345678);
    check_eq("midstart_no_err", 64'(err_cnt - base_err), 64'd0);

    // Reset during the 8th bit of a left word, with a stalled pair pending
    base_sz = got_q.size();
    set_ready(0);
    send_slot(0, 16'hAAAA, 32);
    send_slot(1, 16'hBBBB, 32);
    send_slot(0, 16'($urandom), 32, 3, 8, 10);
    set_ready(1);
    send_slot(1, 16'($urandom), 32);
    send_slot(0, 16'h8001, 32);
    send_slot(1, 16'h7FFE, 32);
    check_eq("rstshift_cnt", 64'(got_q.size() - base_sz), 64'd1);
    if (got_q.size() > 0) check_eq("rstshift_pair", 64'(got_q[$]), 64'h80017FFE);

    // Random frames: random words, slot lengths, occasional short slots and stalls
    for (int f = 0; f < 30; f++) begin
      set_ready($urandom_range(0, 3) != 0);
      for (int c = 0; c < 2; c++) begin
        int len;
        len = ($urandom_range(0, 6) == 0) ? int'($urandom_range(3, 16)) : int'($urandom_range(17, 32));
        send_slot(c[0], 16'($urandom), len);
      end
    end
    set_ready(1);
    repeat (20) @(posedge mclk);
    #1;

    check_eq("total_pairs", 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check_eq($sformatf("pair_%0d", i), 64'(got_q[i]), 64'(exp_q[i]));
    check_eq("total_overrun", 64'(ovr_cnt), 64'(exp_ovr));
    check_eq("total_frame_err", 64'(err_cnt), 64'(exp_err));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
